fetch_unit_bp: RTL and testbench

//  Parametrised IF stage for the 5-stage MIPS pipeline: owns the PC, drives the I-cache and fills the IF/ID register.

---
 rtl/fetch_unit_bp.sv | 158 +++++++++++++++
 tb/tb_fetch_unit_bp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_bp.sv
// IF stage for the 5-stage MIPS pipeline: owns the PC, drives the I-cache, fills IF/ID,
// and predicts taken branches/jumps through a direct-mapped BTB with 2-bit counters.
module fetch_unit_bp #(
  parameter int          IDX_W       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [1:0]  CNT_INIT    = 2'b10,
  parameter int          ENABLE_PRED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  input  logic        hold,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_npc,
  input  logic        rs_valid,
  input  logic [31:0] rs_pc,
  input  logic        rs_is_br,
  input  logic        rs_taken,
  input  logic [31:0] rs_target,
  input  logic        rs_redirect,
  input  logic [31:0] rs_npc
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {RUN, WAIT} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
    logic [31:0] npc;
  } ifid_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  state_e      state_q, state_d;
  ifid_t       ifid_q, ifid_d;

  logic [N-1:0]     val_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       cnt_q [N];

  // Lookup on the current PC
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit, pred;
  logic [31:0]      npc;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[31:IDX_W+2];
  assign lk_hit = val_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred   = (ENABLE_PRED != 0) && lk_hit && cnt_q[lk_idx][1];
  assign npc    = pred ? tgt_q[lk_idx] : pc_q + 32'd4;

  // Resolution feedback from ID is only meaningful while the pipe is not held
  logic             redir_en, tr_en, tr_hit;
  logic [IDX_W-1:0] tr_idx;
  logic [TAG_W-1:0] tr_tag;
  logic             unused_ok;

  assign redir_en  = rs_valid && rs_redirect && !hold;
  assign tr_en     = rs_valid && rs_is_br && !hold;
  assign tr_idx    = rs_pc[IDX_W+1:2];
  assign tr_tag    = rs_pc[31:IDX_W+2];
  assign tr_hit    = val_q[tr_idx] && (tag_q[tr_idx] == tr_tag);
  assign unused_ok = ^rs_pc[1:0];

  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    state_d = state_q;
    ifid_d  = ifid_q;
    if (redir_en) begin
      ifid_d = '0;
      if (!ICACHE_stall) begin
        pc_d    = rs_npc;
        state_d = RUN;
      end else begin
        // Keep the cache address stable until the pending miss returns
        redir_d = rs_npc;
        state_d = WAIT;
      end
    end else if (state_q == WAIT) begin
      ifid_d = '0;
      if (!ICACHE_stall) begin
        pc_d    = redir_q;
        state_d = RUN;
      end
    end else if (!hold) begin
      if (ICACHE_stall) begin
        ifid_d = '0;
      end else begin
        pc_d   = npc;
        ifid_d = '{valid: 1'b1, pc: pc_q, inst: ICACHE_rdata, pred: pred, npc: npc};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      redir_q <= '0;
      state_q <= RUN;
      ifid_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      state_q <= state_d;
      ifid_q  <= ifid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (tr_en) begin
      if (tr_hit) begin
        if (rs_taken) begin
          tgt_q[tr_idx] <= rs_target;
          if (cnt_q[tr_idx] != 2'd3) cnt_q[tr_idx] <= cnt_q[tr_idx] + 2'd1;
        end else if (cnt_q[tr_idx] != 2'd0) begin
          cnt_q[tr_idx] <= cnt_q[tr_idx] - 2'd1;
        end
      end else if (rs_taken) begin
        val_q[tr_idx] <= 1'b1;
        tag_q[tr_idx] <= tr_tag;
        tgt_q[tr_idx] <= rs_target;
        cnt_q[tr_idx] <= CNT_INIT;
      end
    end
  end

  assign ICACHE_ren    = 1'b1;
  assign ICACHE_wen    = 1'b0;
  assign ICACHE_addr   = pc_q[31:2];
  assign ICACHE_wdata  = '0;
  assign if_valid      = ifid_q.valid;
  assign if_pc         = ifid_q.pc;
  assign if_inst       = ifid_q.inst;
  assign if_pred_taken = ifid_q.pred;
  assign if_pred_npc   = ifid_q.npc;
endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp: one predicting instance and one with prediction disabled,
// both fed the same control stimulus; I-cache returns {addr, 2'b11}.
module tb_fetch_unit_bp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, hold;
  logic        rs_valid, rs_is_br, rs_taken, rs_redirect;
  logic [31:0] rs_pc, rs_target, rs_npc;

  logic        ren, wen, vld, ptk;
  logic [29:0] addr;
  logic [31:0] wdata, rdata, ipc, inst, pnpc;
  logic        d0_ren, d0_wen, d0_vld, d0_ptk;
  logic [29:0] d0_addr;
  logic [31:0] d0_wdata, d0_rdata, d0_ipc, d0_inst, d0_pnpc;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;
  assign rdata    = {addr, 2'b11};
  assign d0_rdata = {d0_addr, 2'b11};

  fetch_unit_bp dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_ren(ren), .ICACHE_wen(wen), .ICACHE_addr(addr), .ICACHE_wdata(wdata),
    .ICACHE_stall(stall), .ICACHE_rdata(rdata), .hold(hold),
    .if_valid(vld), .if_pc(ipc), .if_inst(inst), .if_pred_taken(ptk), .if_pred_npc(pnpc),
    .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_is_br(rs_is_br), .rs_taken(rs_taken),
    .rs_target(rs_target), .rs_redirect(rs_redirect), .rs_npc(rs_npc)
  );

  fetch_unit_bp #(.ENABLE_PRED(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_ren(d0_ren), .ICACHE_wen(d0_wen), .ICACHE_addr(d0_addr), .ICACHE_wdata(d0_wdata),
    .ICACHE_stall(stall), .ICACHE_rdata(d0_rdata), .hold(hold),
    .if_valid(d0_vld), .if_pc(d0_ipc), .if_inst(d0_inst), .if_pred_taken(d0_ptk), .if_pred_npc(d0_pnpc),
    .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_is_br(rs_is_br), .rs_taken(rs_taken),
    .rs_target(rs_target), .rs_redirect(rs_redirect), .rs_npc(rs_npc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rs(input logic [31:0] p, input logic br, input logic tk,
                          input logic [31:0] tg, input logic rd, input logic [31:0] n);
    rs_valid = 1'b1; rs_pc = p; rs_is_br = br; rs_taken = tk;
    rs_target = tg; rs_redirect = rd; rs_npc = n;
  endtask

  task automatic clr_rs;
    rs_valid = 1'b0; rs_pc = '0; rs_is_br = 1'b0; rs_taken = 1'b0;
    rs_target = '0; rs_redirect = 1'b0; rs_npc = '0;
  endtask

  logic [6:0] tk_seq = 7'b1000011;
  logic [6:0] pr_seq = 7'b0000111;

  initial begin
    rst_n = 1'b0; stall = 1'b0; hold = 1'b0;
    clr_rs();
    #12;
    chk("rst_addr", {2'b0, addr}, 32'h0);
    chk("rst_valid", {31'b0, vld}, 32'h0);
    chk("rst_pc", ipc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("ren_wen", {30'b0, ren, wen}, 32'h2);
    rst_n = 1'b1;

    // sequential fetch
    step;
    chk("seq0_addr", {2'b0, addr}, 32'h1);
    chk("seq0_valid", {31'b0, vld}, 32'h1);
    chk("seq0_pc", ipc, 32'h0);
    chk("seq0_inst", inst, 32'h3);
    chk("seq0_ptk", {31'b0, ptk}, 32'h0);
    chk("seq0_npc", pnpc, 32'h4);
    step;
    chk("seq1_addr", {2'b0, addr}, 32'h2);
    chk("seq1_pc", ipc, 32'h4);
    step;
    chk("seq2_addr", {2'b0, addr}, 32'h3);
    chk("seq2_pc", ipc, 32'h8);
    step;
    step;
    chk("seq4_pc", ipc, 32'h10);

    // beq@0x10 resolves taken -> 0x04 with redirect; allocates BTB entry
    drive_rs(32'h10, 1'b1, 1'b1, 32'h4, 1'b1, 32'h4);
    step;
    clr_rs();
    chk("redir_addr", {2'b0, addr}, 32'h1);
    chk("redir_bubble", {31'b0, vld}, 32'h0);
    step; step; step;
    chk("pass2_addr", {2'b0, addr}, 32'h4);
    step;
    chk("pass2_pc", ipc, 32'h10);
    chk("pass2_ptk", {31'b0, ptk}, 32'h1);
    chk("pass2_npc", pnpc, 32'h4);
    chk("pass2_valid", {31'b0, vld}, 32'h1);
    chk("pass2_next", {2'b0, addr}, 32'h1);

    // counter walk from 2: T,T(sat),NT,NT,NT,NT(sat),T
    for (int i = 0; i < 7; i++) begin
      drive_rs(32'h10, 1'b1, tk_seq[i], 32'h4, 1'b1, 32'h10);
      step;
      clr_rs();
      chk("cnt_redir", {2'b0, addr}, 32'h4);
      step;
      chk($sformatf("cnt_ptk%0d", i), {31'b0, ptk}, {31'b0, pr_seq[i]});
      chk($sformatf("cnt_npc%0d", i), pnpc, pr_seq[i] ? 32'h4 : 32'h14);
    end

    // redirect to 0x40 during a 3-cycle I-cache stall
    stall = 1'b1;
    drive_rs(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    step;
    clr_rs();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step;
      chk($sformatf("wait%0d_addr", i), {2'b0, addr}, 32'h5);
      chk($sformatf("wait%0d_valid", i), {31'b0, vld}, 32'h0);
      chk($sformatf("wait%0d_inst", i), inst, 32'h0);
    end
    stall = 1'b0;
    step;
    chk("wait_done_addr", {2'b0, addr}, 32'h10);
    chk("wait_done_valid", {31'b0, vld}, 32'h0);
    step;
    chk("wait_fetch_pc", ipc, 32'h40);
    chk("wait_fetch_inst", inst, 32'h43);
    chk("wait_fetch_valid", {31'b0, vld}, 32'h1);

    // hold for 2 cycles with a pending redirect + allocation of 0x20
    hold = 1'b1;
    drive_rs(32'h20, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80);
    for (int i = 0; i < 2; i++) begin
      step;
      chk($sformatf("hold%0d_addr", i), {2'b0, addr}, 32'h11);
      chk($sformatf("hold%0d_pc", i), ipc, 32'h40);
      chk($sformatf("hold%0d_valid", i), {31'b0, vld}, 32'h1);
    end
    hold = 1'b0;
    step;
    clr_rs();
    chk("hold_rel_addr", {2'b0, addr}, 32'h20);
    chk("hold_rel_valid", {31'b0, vld}, 32'h0);
    drive_rs(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    step;
    clr_rs();
    step;
    chk("alloc_ptk", {31'b0, ptk}, 32'h1);
    chk("alloc_npc", pnpc, 32'h100);
    chk("alloc_addr", {2'b0, addr}, 32'h40);
    // a single allocation leaves cnt=2, so one not-taken must flip the prediction
    drive_rs(32'h20, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
    step;
    clr_rs();
    step;
    chk("once_ptk", {31'b0, ptk}, 32'h0);
    chk("once_npc", pnpc, 32'h24);

    // prediction disabled: trained entry ignored, PC wraps
    drive_rs(32'h20, 1'b1, 1'b1, 32'h100, 1'b1, 32'h20);
    step;
    clr_rs();
    chk("np_addr", {2'b0, d0_addr}, 32'h8);
    step;
    chk("p_ptk", {31'b0, ptk}, 32'h1);
    chk("np_ptk", {31'b0, d0_ptk}, 32'h0);
    chk("np_npc", d0_pnpc, 32'h24);
    chk("np_next", {2'b0, d0_addr}, 32'h9);
    drive_rs(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step;
    clr_rs();
    chk("wrap_addr", {2'b0, d0_addr}, 32'h3FFF_FFFF);
    step;
    chk("wrap_pc", d0_ipc, 32'hFFFF_FFFC);
    chk("wrap_npc", d0_pnpc, 32'h0);
    chk("wrap_next", {2'b0, d0_addr}, 32'h0);
    chk("wrap_next_p", {2'b0, addr}, 32'h0);

    // reset in WAIT drops the pending redirect
    stall = 1'b1;
    drive_rs(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    step;
    clr_rs();
    rst_n = 1'b0;
    #1;
    chk("mrst_addr", {2'b0, addr}, 32'h0);
    chk("mrst_valid", {31'b0, vld}, 32'h0);
    step;
    rst_n = 1'b1;
    stall = 1'b0;
    step;
    chk("mrst_run_addr", {2'b0, addr}, 32'h1);
    chk("mrst_run_pc", ipc, 32'h0);
    chk("mrst_run_valid", {31'b0, vld}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
